// File: rtl/ar_rxd_chk.sv
// ar_rxd_chk: ARINC429 receiver (sync, glitch filter, framing, odd parity, error pulses); optional label filter via LABEL_FILTER_EN
module ar_rxd_chk #(
  parameter int CLK_HZ = 50_000_000,
  parameter int FILT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Nvel,
  input  logic        in0,
  input  logic        in1,
`ifdef LABEL_FILTER_EN
  input  logic [7:0]  lbl_val,
  input  logic [7:0]  lbl_msk,
`endif
  output logic [7:0]  sr_adr,
  output logic [22:0] sr_dat,
  output logic        ce_wr,
  output logic        err_par,
  output logic        err_frm,
  output logic        busy
);
  localparam int BT0 = CLK_HZ / 12_500;
  localparam int BT1 = CLK_HZ / 50_000;
  localparam int BT2 = CLK_HZ / 100_000;
  localparam int TW  = $clog2(2 * BT0 + 2);
  localparam int FW  = $clog2(FILT + 1);
  localparam logic [TW-1:0] SY0 = TW'(2 * BT0);
  localparam logic [TW-1:0] SY1 = TW'(2 * BT1);
  localparam logic [TW-1:0] SY2 = TW'(2 * BT2);
  localparam logic [TW-1:0] TO0 = TW'(3 * BT0 / 2);
  localparam logic [TW-1:0] TO1 = TW'(3 * BT1 / 2);
  localparam logic [TW-1:0] TO2 = TW'(3 * BT2 / 2);
  localparam logic [FW-1:0] FLIM = FW'(FILT - 1);
  // line levels as {in1, in0}
  localparam logic [1:0] NUL = 2'b00, LO = 2'b01, HI = 2'b10, BAD = 2'b11;
  typedef enum logic [1:0] {SYNC, IDLE, RECV, CHECK} state_t;
  state_t        state_q, state_d;
  logic [1:0]    s1_q, s2_q, cand_q, cand_d, filt_q, filt_d, rate_q, rate_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [TW-1:0] tmr_q, tmr_d, sync_lim, to_lim;
  logic [31:0]   sh_q, sh_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [7:0]    adr_q, adr_d;
  logic [22:0]   dat_q, dat_d, rev;
  logic          ce_q, ce_d, ep_q, ep_d, ef_q, ef_d, busy_q, busy_d;
  logic          bit_ev, bit_v, par_ok, lbl_ok;
  // Filter the synchronised lines, find NUL->HI/LO bit events and compute the framing FSM's next state
  always_comb begin
    cand_d = s2_q;
    fcnt_d = (s2_q != cand_q) ? FW'(1) : (fcnt_q >= FLIM) ? fcnt_q : fcnt_q + FW'(1);
    filt_d = (s2_q == cand_q && fcnt_q >= FLIM) ? cand_q : filt_q;
    bit_ev = (filt_q == NUL) && (filt_d == HI || filt_d == LO);
    bit_v = (filt_d == HI);
    sync_lim = (Nvel == 2'b00) ? SY0 : (Nvel == 2'b01) ? SY1 : SY2;
    to_lim = (rate_q == 2'b00) ? TO0 : (rate_q == 2'b01) ? TO1 : TO2;
    tmr_d = (bit_ev || (state_q == SYNC && filt_q != NUL)) ? '0 : (&tmr_q) ? tmr_q : tmr_q + TW'(1);
    rev = '0;
    for (int i = 0; i < 23; i++) rev[i] = sh_q[23 - i];
    par_ok = ^sh_q;
`ifdef LABEL_FILTER_EN
    lbl_ok = ((sh_q[31:24] ^ lbl_val) & lbl_msk) == 8'h00;
`else
    lbl_ok = 1'b1;
`endif
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    rate_d = rate_q;
    busy_d = busy_q;
    adr_d = adr_q;
    dat_d = dat_q;
    ce_d = 1'b0;
    ep_d = 1'b0;
    ef_d = 1'b0;
    case (state_q)
      SYNC: state_d = (filt_q == NUL && tmr_q >= sync_lim) ? IDLE : SYNC;
      IDLE: if (bit_ev) begin
        state_d = RECV;
        sh_d = {31'b0, bit_v};
        cnt_d = 6'd1;
        rate_d = Nvel;
        busy_d = 1'b1;
      end
      RECV: if (filt_q == BAD) begin
        ef_d = 1'b1;
        busy_d = 1'b0;
        state_d = SYNC;
      end else if (bit_ev) begin
        sh_d = {sh_q[30:0], bit_v};
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'd31) ? CHECK : RECV;
      end else if (tmr_q > to_lim) begin
        ef_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
        ce_d = par_ok && lbl_ok;
        ep_d = !par_ok;
        adr_d = (par_ok && lbl_ok) ? sh_q[31:24] : adr_q;
        dat_d = (par_ok && lbl_ok) ? rev : dat_q;
      end
    endcase
  end
  // Register synchronisers, filter, timer, FSM and outputs; reset drops any word in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= NUL;
      s2_q <= NUL;
      cand_q <= NUL;
      fcnt_q <= '0;
      filt_q <= NUL;
      tmr_q <= '0;
      state_q <= SYNC;
      sh_q <= '0;
      cnt_q <= '0;
      rate_q <= '0;
      busy_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      ce_q <= 1'b0;
      ep_q <= 1'b0;
      ef_q <= 1'b0;
    end else begin
      s1_q <= {in1, in0};
      s2_q <= s1_q;
      cand_q <= cand_d;
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
      tmr_q <= tmr_d;
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      rate_q <= rate_d;
      busy_q <= busy_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      ce_q <= ce_d;
      ep_q <= ep_d;
      ef_q <= ef_d;
    end
  end
  assign sr_adr = adr_q;
  assign sr_dat = dat_q;
  assign ce_wr = ce_q;
  assign err_par = ep_q;
  assign err_frm = ef_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ar_rxd_chk.sv
// tb_ar_rxd_chk: scoreboard bench for ar_rxd_chk with a scaled clock (CLK_HZ=5 MHz -> BT 400/100/50)
module tb_ar_rxd_chk;
  localparam int CLK_HZ = 5_000_000;
  localparam int BT = 50;
  localparam int BTS = 400;
  localparam logic [2:0] K_CE = 3'b001, K_PAR = 3'b010, K_FRM = 3'b100;
  typedef struct {
    logic [2:0]  k;
    logic [7:0]  a;
    logic [22:0] d;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  Nvel = 2'b10;
  logic        in0 = 1'b0;
  logic        in1 = 1'b0;
  logic [7:0]  sr_adr;
  logic [22:0] sr_dat;
  logic        ce_wr, err_par, err_frm, busy;
`ifdef LABEL_FILTER_EN
  logic [7:0]  lbl_val = 8'h00;
  logic [7:0]  lbl_msk = 8'h00;
`endif
  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  int          last_start = 0;
  int          el;
  logic [7:0]  la = 8'h00;
  logic [22:0] ld = 23'h0;

  ar_rxd_chk #(.CLK_HZ(CLK_HZ), .FILT(3)) dut (
    .clk(clk), .reset(reset), .Nvel(Nvel), .in0(in0), .in1(in1),
`ifdef LABEL_FILTER_EN
    .lbl_val(lbl_val), .lbl_msk(lbl_msk),
`endif
    .sr_adr(sr_adr), .sr_dat(sr_dat), .ce_wr(ce_wr), .err_par(err_par),
    .err_frm(err_frm), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] k, input logic [7:0] a, input logic [22:0] d);
    exp_t x;
    x.k = k;
    x.a = a;
    x.d = d;
    q.push_back(x);
  endtask

  // bit n of the returned vector is the n-th bit on the wire
  function automatic logic [1:32] mk(input logic [7:0] l, input logic [22:0] d, input logic bad);
    logic [1:32] b;
    for (int n = 1; n <= 8; n++) b[n] = l[8-n];
    for (int n = 9; n <= 31; n++) b[n] = d[n-9];
    b[32] = ~(^b[1:31]) ^ bad;
    return b;
  endfunction

  // RZ bits from..to; gl = bit carrying 1-cycle glitches, tog = bit at which Nvel is forced to 00
  task automatic send(input logic [1:32] w, input int from, input int to, input int bt, input int gl, input int tog);
    for (int n = from; n <= to; n++) begin
      if (n == tog) Nvel = 2'b00;
      last_start = cyc_cnt;
      in1 = w[n];
      in0 = ~w[n];
      if (n == gl) begin
        cyc(bt / 4);
        in1 = 1'b1;
        in0 = 1'b1;
        cyc(1);
        in1 = w[n];
        in0 = ~w[n];
        cyc(bt / 2 - bt / 4 - 1);
      end else cyc(bt / 2);
      in1 = 1'b0;
      in0 = 1'b0;
      if (n == gl) begin
        cyc(bt / 4);
        in1 = 1'b1;
        cyc(1);
        in1 = 1'b0;
        cyc(bt - bt / 2 - bt / 4 - 1);
      end else cyc(bt - bt / 2);
    end
  endtask

  task automatic good(input logic [7:0] l, input logic [22:0] d, input int gl, input int tog);
    la = l;
    ld = d;
    push(K_CE, l, d);
    send(mk(l, d, 1'b0), 1, 32, BT, gl, tog);
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && q.size() != 0; i++) cyc(1);
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  // monitor: every strobe/pulse must match the oldest expected event
  always @(negedge clk)
    if (reset && (ce_wr || err_par || err_frm)) begin
      if (q.size() == 0) chk("unexpected", {29'b0, err_frm, err_par, ce_wr}, 32'd0);
      else begin
        e = q.pop_front();
        chk("kind", {29'b0, err_frm, err_par, ce_wr}, {29'b0, e.k});
        chk("busy_end", {31'b0, busy}, 32'd0);
        if (e.k != K_FRM) begin
          chk("sr_adr", {24'b0, sr_adr}, {24'b0, e.a});
          chk("sr_dat", {9'b0, sr_dat}, {9'b0, e.d});
        end
      end
    end

  initial begin
    #2 reset = 1'b0;
    cyc(3);
    chk("rst_adr", {24'b0, sr_adr}, 32'd0);
    chk("rst_dat", {9'b0, sr_dat}, 32'd0);
    chk("rst_flags", {28'b0, busy, err_frm, err_par, ce_wr}, 32'd0);
    reset = 1'b1;
    cyc(5 * BT);
    good(8'o203, 23'h12345, 0, 0);
    drain(100);
    chk("word1_adr", {24'b0, sr_adr}, 32'h83);
    push(K_PAR, la, ld);
    send(mk(8'o203, 23'h12345, 1'b1), 1, 32, BT, 0, 0);
    drain(100);
    Nvel = 2'b00;
    push(K_FRM, 8'h0, 23'h0);
    send(mk(8'h55, 23'h2AAAAA, 1'b0), 1, 20, BTS, 0, 0);
    el = -1;
    for (int i = 0; i < 1000 && el < 0; i++) begin
      @(negedge clk);
      if (err_frm) el = cyc_cnt - last_start;
    end
    // raw line edge to filtered event adds the 2-FF synchroniser to the 6000-scaled (600) window
    chk("tmo_window", 32'(el >= 602 && el <= 608), 32'd1);
    drain(100);
    Nvel = 2'b10;
    cyc(BT);
    good(8'h2A, 23'h55AA33, 0, 0);
    drain(100);
    push(K_FRM, 8'h0, 23'h0);
    send(mk(8'h11, 23'h0, 1'b0), 1, 10, BT, 0, 0);
    in0 = 1'b1;
    in1 = 1'b1;
    cyc(5);
    in0 = 1'b0;
    in1 = 1'b0;
    drain(100);
    cyc(5 * BT);
    good(8'h5C, 23'h0F0F0F, 12, 0);
    drain(100);
    good(8'hC1, 23'h7FFFFE, 0, 0);
    cyc(4 * BT);
    good(8'h01, 23'h000001, 0, 10);
    Nvel = 2'b10;
    drain(100);
    send(mk(8'hFF, 23'h3FFFFF, 1'b0), 1, 16, BT, 0, 0);
    chk("busy_mid", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_adr", {24'b0, sr_adr}, 32'd0);
    chk("mid_rst_dat", {9'b0, sr_dat}, 32'd0);
    chk("mid_rst_flags", {28'b0, busy, err_frm, err_par, ce_wr}, 32'd0);
    cyc(3);
    reset = 1'b1;
    send(mk(8'hFF, 23'h3FFFFF, 1'b0), 17, 32, BT, 0, 0);
    cyc(4 * BT);
    good(8'h3C, 23'h02468A, 0, 0);
    drain(100);
`ifdef LABEL_FILTER_EN
    lbl_val = 8'h83;
    lbl_msk = 8'hFF;
    good(8'h83, 23'h000ABC, 0, 0);
    send(mk(8'h84, 23'h000DEF, 1'b0), 1, 32, BT, 0, 0);
    drain(100);
    chk("lbl_hold", {24'b0, sr_adr}, 32'h83);
`endif
    cyc(2 * BT);
    chk("final_q", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
